// File: rtl/tri_rr_arb_hold_pkg.sv
// Shared types and helpers for the tri_rr_arb_hold round-robin arbiter slice.
// State encodings match the trilib a2o defines so waveforms read the same.
package tri_rr_arb_hold_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      HOLD  = 2'b10
   } arbState_t;

   // Hold counter is sized for the largest legal MAX_HOLD (255).
   localparam int CNT_W = 8;

   function automatic int idWidth(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tri_rr_arb_hold_if.sv
// Request/grant bundle between the requesting units and the arbiter.
// master = requester side, slave = arbiter side.
interface tri_rr_arb_hold_if #(
   parameter int REQ  = 4,
   parameter int ID_W = 2
);
   logic [0:REQ-1]  req;
   logic [0:REQ-1]  lock;
   logic            enable;
   logic [0:REQ-1]  gnt;
   logic            gnt_vld;
   logic [0:ID_W-1] gnt_id;
   logic            timeout;

   modport master (
      output req, lock, enable,
      input  gnt, gnt_vld, gnt_id, timeout
   );

   modport slave (
      input  req, lock, enable,
      output gnt, gnt_vld, gnt_id, timeout
   );
endinterface

// File: rtl/tri_rr_arb_hold_pick.sv
// Combinational rotate-priority picker: first eligible request after ptr wins.
// A set mask bit removes that requester from the scan.
module tri_rr_pick #(
   parameter int REQ  = 4,
   parameter int ID_W = 2
) (
   input  logic [0:REQ-1]  req,
   input  logic [0:REQ-1]  mask,
   input  logic [ID_W-1:0] ptr,
   output logic [0:REQ-1]  winner,
   output logic [ID_W-1:0] winnerId,
   output logic            found
);

   always_comb begin
      // NOTE: combinational logic uses blocking '=' so later statements see
      // the updated 'found'; every output gets a default first so no latch forms.
      winner   = '0;
      winnerId = '0;
      found    = 1'b0;
      for (int k = 1; k <= REQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % REQ;
         if (!found && req[idx] && !mask[idx]) begin
            found       = 1'b1;
            winner[idx] = 1'b1;
            winnerId    = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/tri_rr_arb_hold.sv
// Registered round-robin arbiter with locked multi-cycle ownership and a hold
// timeout; the one-hot grant drives the shared trilib OAI21 stage b0 enables.
module tri_rr_arb_hold
   import tri_rr_arb_hold_pkg::*;
#(
   parameter int REQ      = 4,
   parameter int MAX_HOLD = 15,
   parameter int ID_W     = 2
) (
   input  logic             nclk,
   input  logic             rst_n,
   tri_rr_arb_hold_if.slave bus
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

   if (ID_W != idWidth(REQ)) begin : g_idWidthCheck
      $error("tri_rr_arb_hold: ID_W must equal clog2(REQ)");
   end

   arbState_t        state, stateNxt;
   logic [0:REQ-1]   gntQ, gntNxt, pickMask, winner;
   logic [ID_W-1:0]  gntIdQ, gntIdNxt, ptr, ptrNxt, winnerId;
   logic [CNT_W-1:0] holdCnt, holdCntNxt;
   logic             timeoutQ, found, locked, keepHold, forced;

   // Owner wants to keep the grant; the counter decides whether it may.
   assign locked   = (state != IDLE) && bus.req[gntIdQ] && bus.lock[gntIdQ];
   assign keepHold = locked && (holdCnt < MAX_CNT);
   assign forced   = locked && (holdCnt >= MAX_CNT);
   assign pickMask = forced ? gntQ : '0;

   tri_rr_pick #(
      .REQ  (REQ),
      .ID_W (ID_W)
   ) u_pick (
      .req      (bus.req),
      .mask     (pickMask),
      .ptr      (ptr),
      .winner   (winner),
      .winnerId (winnerId),
      .found    (found)
   );

   always_comb begin
      stateNxt   = IDLE;
      gntNxt     = '0;
      gntIdNxt   = '0;
      ptrNxt     = ptr;
      holdCntNxt = '0;
      if (keepHold) begin
         stateNxt   = HOLD;
         gntNxt     = gntQ;
         gntIdNxt   = gntIdQ;
         holdCntNxt = holdCnt + 1'b1;
      end else if (bus.enable && found) begin
         // Voluntary or forced release re-arbitrates here, so no bubble cycle.
         stateNxt   = GRANT;
         gntNxt     = winner;
         gntIdNxt   = winnerId;
         ptrNxt     = winnerId;
         holdCntNxt = CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so all flops update together.
   always_ff @(posedge nclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gntQ     <= '0;
         gntIdQ   <= '0;
         ptr      <= ID_W'(REQ - 1);
         holdCnt  <= '0;
         timeoutQ <= 1'b0;
      end else begin
         state    <= stateNxt;
         gntQ     <= gntNxt;
         gntIdQ   <= gntIdNxt;
         ptr      <= ptrNxt;
         holdCnt  <= holdCntNxt;
         timeoutQ <= forced;
      end
   end

   assign bus.gnt     = gntQ;
   assign bus.gnt_vld = |gntQ;
   assign bus.gnt_id  = gntIdQ;
   assign bus.timeout = timeoutQ;

endmodule

// File: tb/tb_tri_rr_arb_hold.sv
// Directed bench for tri_rr_arb_hold: vector table plus hold/timeout/reset sequences.
// busA drives the default MAX_HOLD=15 arbiter, busB a MAX_HOLD=3 copy.
module tb_tri_rr_arb_hold;

   typedef struct {
      logic [0:3] req;
      logic [0:3] lock;
      logic       en;
      logic [0:3] gnt;
      int         id;
      logic       to;
   } vec_t;

   logic nclk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 nclk = ~nclk;

   tri_rr_arb_hold_if #(.REQ(4), .ID_W(2)) busA ();
   tri_rr_arb_hold_if #(.REQ(4), .ID_W(2)) busB ();

   tri_rr_arb_hold #(.REQ(4), .MAX_HOLD(15), .ID_W(2)) dutA (
      .nclk  (nclk),
      .rst_n (rst_n),
      .bus   (busA)
   );

   tri_rr_arb_hold #(.REQ(4), .MAX_HOLD(3), .ID_W(2)) dutB (
      .nclk  (nclk),
      .rst_n (rst_n),
      .bus   (busB)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [0:3] r, input logic [0:3] l, input logic e);
      busA.req = r; busA.lock = l; busA.enable = e;
      busB.req = r; busB.lock = l; busB.enable = e;
   endtask

   task automatic tick();
      @(posedge nclk);
      #1;
   endtask

   // useB selects which arbiter is compared.
   task automatic expect_out(input string name, input bit useB, input logic [0:3] g,
                             input int id, input logic to);
      if (useB) begin
         check({name, ".gnt"}, 32'(busB.gnt), 32'(g));
         check({name, ".vld"}, 32'(busB.gnt_vld), 32'(|g));
         check({name, ".id"}, 32'(busB.gnt_id), 32'(id));
         check({name, ".to"}, 32'(busB.timeout), 32'(to));
      end else begin
         check({name, ".gnt"}, 32'(busA.gnt), 32'(g));
         check({name, ".vld"}, 32'(busA.gnt_vld), 32'(|g));
         check({name, ".id"}, 32'(busA.gnt_id), 32'(id));
         check({name, ".to"}, 32'(busA.timeout), 32'(to));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      expect_out("rstA", 1'b0, 4'b0000, 0, 1'b0);
      expect_out("rstB", 1'b1, 4'b0000, 0, 1'b0);
      @(negedge nclk);
      rst_n = 1'b1;
   endtask

   vec_t vecs[15];

   initial begin
      logic [0:3] holdExp [7];
      int         holdId  [7];

      // RR rotation from reset, sparse RR, enable gating, sole requester.
      vecs[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 0, 1'b0};
      vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1, 1'b0};
      vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 2, 1'b0};
      vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 3, 1'b0};
      vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 0, 1'b0};
      vecs[5]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1, 1'b0};
      vecs[6]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 3, 1'b0};
      vecs[7]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1, 1'b0};
      vecs[8]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 3, 1'b0};
      vecs[9]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 0, 1'b0};
      vecs[10] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 0, 1'b0};
      vecs[11] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 0, 1'b0};
      vecs[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 1'b0};
      vecs[13] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 2, 1'b0};
      vecs[14] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 2, 1'b0};

      holdExp = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      holdId  = '{0, 1, 2, 2, 2, 2, 2};

      rst_n = 1'b1;
      drive(4'b1111, 4'b0000, 1'b1);
      #1;
      do_reset();

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].req, vecs[i].lock, vecs[i].en);
         tick();
         expect_out($sformatf("vec%0d", i), 1'b0, vecs[i].gnt, vecs[i].id, vecs[i].to);
      end

      // Requester 2 locks for four cycles, then releases straight to requester 3.
      drive(4'b1111, 4'b0010, 1'b1);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         tick();
         expect_out($sformatf("hold%0d", i), 1'b0, holdExp[i], holdId[i], 1'b0);
      end
      drive(4'b1111, 4'b0000, 1'b1);
      tick();
      expect_out("volrel", 1'b0, 4'b0001, 3, 1'b0);

      // enable falls during a hold: grant kept until lock drops, then idle.
      drive(4'b1111, 4'b0001, 1'b1);
      tick();
      expect_out("enHold0", 1'b0, 4'b0001, 3, 1'b0);
      drive(4'b1111, 4'b0001, 1'b0);
      tick();
      expect_out("enHold1", 1'b0, 4'b0001, 3, 1'b0);
      tick();
      expect_out("enHold2", 1'b0, 4'b0001, 3, 1'b0);
      drive(4'b1111, 4'b0000, 1'b0);
      tick();
      expect_out("enHoldRel", 1'b0, 4'b0000, 0, 1'b0);

      // Timeout with a competitor waiting (MAX_HOLD=3).
      drive(4'b1100, 4'b1000, 1'b1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("toHold%0d", i), 1'b1, 4'b1000, 0, 1'b0);
      end
      tick();
      expect_out("toForce", 1'b1, 4'b0100, 1, 1'b1);
      tick();
      expect_out("toAfter", 1'b1, 4'b1000, 0, 1'b0);

      // Timeout with no competitor: one idle cycle, then regranted.
      drive(4'b1000, 4'b1000, 1'b1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("toSoloHold%0d", i), 1'b1, 4'b1000, 0, 1'b0);
      end
      tick();
      expect_out("toSoloIdle", 1'b1, 4'b0000, 0, 1'b1);
      tick();
      expect_out("toSoloRegrant", 1'b1, 4'b1000, 0, 1'b0);

      // Asynchronous reset between edges while in HOLD.
      drive(4'b1111, 4'b1000, 1'b1);
      do_reset();
      tick();
      expect_out("arHold0", 1'b0, 4'b1000, 0, 1'b0);
      tick();
      expect_out("arHold1", 1'b0, 4'b1000, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("arMid", 1'b0, 4'b0000, 0, 1'b0);
      drive(4'b1111, 4'b0000, 1'b1);
      @(negedge nclk);
      rst_n = 1'b1;
      tick();
      expect_out("arFirst", 1'b0, 4'b1000, 0, 1'b0);
      tick();
      expect_out("arSecond", 1'b0, 4'b0100, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tri_rr_arb_hold.md
Name: tri_rr_arb_hold

Overview:
- Registered round-robin arbiter that shares one trilib gated-output resource among REQ requesters.
- The resource is an OAI21-style enable/select stage; the one-hot grant drives its b0 enables.
- Supports single-cycle grants and locked multi-cycle ownership, with a hold timeout so no requester can starve the others.
- Sits between requesting units and the shared trilib datapath slice.

Parameters:
- REQ, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 15, maximum consecutive cycles one owner may keep a locked grant; legal range 1..255.
- ID_W, 2, width of gnt_id; must equal clog2(REQ), minimum 1.

Ports:
- nclk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  [0:REQ-1]  request vector; index 0 is the leftmost bit.
- lock  input  [0:REQ-1]  owner asks to keep its grant next cycle; only meaningful for the current owner.
- enable  input  1  allows new grants; does not affect an ongoing hold.
- gnt  output  [0:REQ-1]  registered one-hot grant; all zero when idle.
- gnt_vld  output  1  equals OR of gnt.
- gnt_id  output  [0:ID_W-1]  binary index of the granted requester; 0 when idle.
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, gnt_vld=0, gnt_id=0, timeout=0, state=IDLE, ptr=REQ-1, hold_cnt=0. Effect is immediate, mid-hold included; the first arbitration after reset gives index 0 highest priority.
- States:
  - IDLE: no owner.
  - GRANT: owner granted this cycle, not locked.
  - HOLD: owner locked.
- Arbitration, combinational, evaluated every cycle a new grant is permitted:
  - Scan req starting at index ptr+1, wrapping modulo REQ; pick the first set bit.
  - The result is registered, so gnt appears one cycle after req is sampled.
  - ptr loads the winner's index when the winner is registered.
- New grant permitted when:
  - state is IDLE or GRANT, or
  - state is HOLD and the owner is releasing this cycle;
  - and, in every case, enable=1.
- If enable=0 and no hold continues, gnt goes to zero next cycle and state goes to IDLE.
- IDLE/GRANT transitions:
  - Winner found -> GRANT, with hold_cnt=1.
  - No winner -> IDLE.
- GRANT -> HOLD when lock[owner]=1 and req[owner]=1 in the GRANT cycle. gnt stays unchanged and hold_cnt increments.
- HOLD continues while req[owner]=1, lock[owner]=1 and hold_cnt<MAX_HOLD; hold_cnt increments each cycle. The grant is held regardless of enable.
- Voluntary release: req[owner]=0 or lock[owner]=0 while in HOLD.
  - Re-arbitrate in the same cycle, so there is no bubble.
  - The owner is eligible only if req[owner] is still 1; RR order naturally puts it last.
- Forced release: in HOLD with hold_cnt==MAX_HOLD and lock still set.
  - timeout=1 on the next edge, for one cycle.
  - The owner is masked from the arbitration done in that cycle.
  - If no other requester is active: gnt=0, state=IDLE.
- Grant count: a non-locked sole requester with req held receives gnt on consecutive cycles.
- Ignored inputs: lock bits of non-owners have no effect; req bits at or beyond REQ do not exist.
- hold_cnt saturates at MAX_HOLD and never wraps.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id is consistent with gnt in the same cycle.
  - At most one grant change per cycle.

Decomposition:
- Shared include (tri_a2o.vh style defines): state encodings IDLE=2'b00, GRANT=2'b01, HOLD=2'b10, plus the clog2 macro used for ID_W checks.
- One natural sub-module: tri_rr_pick, a purely combinational rotate-priority picker.
  - Inputs: req, mask, ptr.
  - Outputs: one-hot winner, index, found.
- Everything else lives in the top level: state register, ptr, hold_cnt, output flops.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, gnt_vld=0, gnt_id=0, timeout=0. After release, gnt sequence is 1000, 0100, 0010, 0001, 1000 on successive cycles.
- Sparse RR: req=4'b0101 held, lock=0 -> gnt alternates 0100, 0001; gnt_id alternates 1, 3.
- Locked hold and voluntary release: requester 2 granted with lock[2]=1 for 4 cycles while req=4'b1111 -> gnt=0010 for 5 cycles. lock[2] drops -> next cycle gnt=0001, no idle cycle.
- Timeout: MAX_HOLD=3, req=4'b1100, lock=4'b1000 held -> gnt=1000 for 3 cycles, timeout pulse, then gnt=0100. With req=4'b1000 only -> gnt=0, state IDLE for one cycle, then regranted.
- enable: enable=0 with req=4'b1111 -> gnt stays 0. An ongoing HOLD while enable falls keeps gnt until release, then gnt=0.
- Async reset mid-HOLD: assert rst_n low between clock edges during HOLD -> gnt=0 immediately. After deassert, the first grant goes to index 0.
